spi_master_xfer: RTL and testbench

SPI_MASTER_XFER -- requirements
Module: spi_master_xfer

---
 rtl/spi_master_pkg.sv | 16 +
 rtl/spi_clk_div.sv | 29 ++
 rtl/spi_master_xfer.sv | 154 +++++++++++++++
 tb/tb_spi_master_xfer.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_master_pkg.sv
// Shared definitions for the SPI byte-transfer master: FSM state type and
// default timing parameters.
package spi_master_pkg;

  localparam int DEFAULT_CLK_DIV        = 4;
  localparam int DEFAULT_CS_IDLE_CYCLES = 2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHIFT_LO = 3'd1,
    SHIFT_HI = 3'd2,
    HOLD     = 3'd3,
    CS_GAP   = 3'd4
  } spi_state_e;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period counter for the SPI clock: one-cycle tick every CLK_DIV clk
// cycles while enabled; the count is held at zero whenever disabled.
module spi_clk_div
  import spi_master_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam logic [7:0] LAST_COUNT = 8'(CLK_DIV - 1);

  logic [7:0] count;

  assign tick = enable && (count == LAST_COUNT);

  // Wrapping on every tick keeps each sck half-period exactly CLK_DIV cycles.
  always_ff @(posedge clk) begin
    if (reset || !enable || tick) begin
      count <= '0;
    end else begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/spi_master_xfer.sv
// Mode-0 SPI master that shifts one byte per handshake, MSB first, holding
// chip select low across bursts until a byte flagged txLast completes.
module spi_master_xfer
  import spi_master_pkg::*;
#(
  parameter int CLK_DIV        = DEFAULT_CLK_DIV,
  parameter int CS_IDLE_CYCLES = DEFAULT_CS_IDLE_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] txData,
  input  logic       txDc,
  input  logic       txLast,
  input  logic       txValid,
  output logic       txReady,
  output logic [7:0] rxData,
  output logic       rxValid,
  output logic       busy,
  output logic       sck,
  output logic       cs,
  output logic       serialDataOut,
  input  logic       serialDataIn,
  output logic       dcOut
);

  localparam logic [7:0] GAP_LAST = 8'(CS_IDLE_CYCLES - 1);

  spi_state_e state;
  logic [7:0] tx_shift;
  logic [7:0] rx_shift;
  logic [2:0] bit_count;
  logic [7:0] gap_count;
  logic       last_byte;

  logic div_enable;
  logic tick;
  logic accept;
  logic rise_tick;
  logic fall_tick;
  logic byte_done;

  assign txReady    = !reset && ((state == IDLE) || (state == HOLD));
  assign busy       = (state != IDLE);
  assign accept     = txValid && txReady;
  assign div_enable = (state == SHIFT_LO) || (state == SHIFT_HI);
  assign rise_tick  = tick && (state == SHIFT_LO);
  assign fall_tick  = tick && (state == SHIFT_HI);
  assign byte_done  = fall_tick && (bit_count == 3'd7);

  spi_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_div (
    .clk   (clk),
    .reset (reset),
    .enable(div_enable),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      gap_count <= '0;
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (accept) begin
            state <= SHIFT_LO;
          end
        end
        SHIFT_LO: begin
          if (rise_tick) begin
            state <= SHIFT_HI;
          end
        end
        SHIFT_HI: begin
          if (byte_done) begin
            state     <= last_byte ? CS_GAP : HOLD;
            gap_count <= '0;
          end else if (fall_tick) begin
            state <= SHIFT_LO;
          end
        end
        CS_GAP: begin
          if (gap_count == GAP_LAST) begin
            state <= IDLE;
          end else begin
            gap_count <= gap_count + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The byte's fields are captured at accept so later input changes cannot
  // disturb the frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_shift      <= '0;
      serialDataOut <= 1'b0;
      dcOut         <= 1'b0;
      last_byte     <= 1'b0;
      bit_count     <= '0;
    end else if (accept) begin
      serialDataOut <= txData[7];
      tx_shift      <= {txData[6:0], 1'b0};
      dcOut         <= txDc;
      last_byte     <= txLast;
      bit_count     <= '0;
    end else if (fall_tick && !byte_done) begin
      serialDataOut <= tx_shift[7];
      tx_shift      <= {tx_shift[6:0], 1'b0};
      bit_count     <= bit_count + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_shift <= '0;
      rxData   <= '0;
      rxValid  <= 1'b0;
    end else begin
      rxValid <= byte_done;
      if (rise_tick) begin
        rx_shift <= {rx_shift[6:0], serialDataIn};
      end
      if (byte_done) begin
        rxData <= rx_shift;
      end
    end
  end

  // cs only rises when a txLast byte finishes, so HOLD keeps it low.
  always_ff @(posedge clk) begin
    if (reset) begin
      sck <= 1'b0;
      cs  <= 1'b1;
    end else begin
      if (accept) begin
        cs <= 1'b0;
      end else if (byte_done && last_byte) begin
        cs <= 1'b1;
      end
      if (accept) begin
        sck <= 1'b0;
      end else if (rise_tick) begin
        sck <= 1'b1;
      end else if (fall_tick) begin
        sck <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_xfer.sv
// Scoreboard bench for spi_master_xfer: a loopback instance at CLK_DIV=4 and
// an instance at CLK_DIV=1 talking to a mode-0 slave model.
module tb_spi_master_xfer;

  typedef struct {
    logic [7:0] data;
    time        acc;
  } exp_t;

  logic       clk;
  logic       reset;

  logic [7:0] tx_data;
  logic       tx_dc;
  logic       tx_last;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy0;
  logic       sck0;
  logic       cs0;
  logic       mosi0;
  logic       miso0;
  logic       dc0;

  logic [7:0] tx1_data;
  logic       tx1_valid;
  logic       tx1_ready;
  logic [7:0] rx1_data;
  logic       rx1_valid;
  logic       busy1;
  logic       sck1;
  logic       cs1;
  logic       mosi1;
  logic       miso1;
  logic       dc1;

  logic [7:0] slave_load;
  logic [7:0] slave_sr;

  int compared;
  int mismatched;
  int sck0_rises;
  int sck1_rises;
  int rx0_pulses;
  int cs_breaks;
  bit watch_cs;
  time sck1_last_rise;
  time sck1_prev_rise;

  exp_t q0[$];
  exp_t q1[$];

  assign miso0 = mosi0;
  assign miso1 = slave_sr[7];

  spi_master_xfer #(.CLK_DIV(4), .CS_IDLE_CYCLES(2)) dut0 (
    .clk(clk), .reset(reset), .txData(tx_data), .txDc(tx_dc), .txLast(tx_last),
    .txValid(tx_valid), .txReady(tx_ready), .rxData(rx_data), .rxValid(rx_valid),
    .busy(busy0), .sck(sck0), .cs(cs0), .serialDataOut(mosi0),
    .serialDataIn(miso0), .dcOut(dc0)
  );

  spi_master_xfer #(.CLK_DIV(1), .CS_IDLE_CYCLES(2)) dut1 (
    .clk(clk), .reset(reset), .txData(tx1_data), .txDc(1'b0), .txLast(1'b1),
    .txValid(tx1_valid), .txReady(tx1_ready), .rxData(rx1_data), .rxValid(rx1_valid),
    .busy(busy1), .sck(sck1), .cs(cs1), .serialDataOut(mosi1),
    .serialDataIn(miso1), .dcOut(dc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mode-0 slave: presents the MSB while cs is high, shifts on sck fall.
  always @(negedge sck1 or posedge cs1) begin
    if (cs1) slave_sr <= slave_load;
    else     slave_sr <= {slave_sr[6:0], 1'b0};
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reportTimeout(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: timed out at %0t", name, $time);
  endtask

  always @(posedge sck0) sck0_rises++;

  always @(posedge sck1) begin
    sck1_prev_rise = sck1_last_rise;
    sck1_last_rise = $time;
    sck1_rises++;
  end

  always @(negedge clk) begin
    if (watch_cs && cs0 && !rx_valid) cs_breaks++;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rx_valid) begin
      rx0_pulses++;
      if (q0.size() == 0) begin
        reportTimeout("rx0_unexpected_pulse");
      end else begin
        e = q0.pop_front();
        checkOutput("rx0_data", 32'(rx_data), 32'(e.data));
        checkOutput("rx0_latency", 32'($time - e.acc), 32'(16 * 4 * 10 + 5));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rx1_valid) begin
      if (q1.size() == 0) begin
        reportTimeout("rx1_unexpected_pulse");
      end else begin
        e = q1.pop_front();
        checkOutput("rx1_data", 32'(rx1_data), 32'(e.data));
        checkOutput("rx1_latency", 32'($time - e.acc), 32'(16 * 1 * 10 + 5));
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] d, input logic dc, input logic last,
                               input bit push, input bit keep_valid);
    int n;
    n = 0;
    tx_data  = d;
    tx_dc    = dc;
    tx_last  = last;
    tx_valid = 1'b1;
    while (!tx_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready) begin
      reportTimeout("accept_wait");
      tx_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (push) q0.push_back('{data: d, acc: $time});
    #1;
    if (!keep_valid) tx_valid = 1'b0;
    checkOutput("start_cs", 32'(cs0), 32'(0));
    checkOutput("start_sck", 32'(sck0), 32'(0));
    checkOutput("start_mosi", 32'(mosi0), 32'(d[7]));
    checkOutput("start_dc", 32'(dc0), 32'(dc));
  endtask

  task automatic waitRx0();
    int n;
    bit ok;
    n = 0;
    ok = 1'b0;
    while (!ok && n < 3000) begin
      @(negedge clk);
      if (rx_valid) ok = 1'b1;
      n++;
    end
    if (!ok) reportTimeout("rx0_wait");
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r0;
    int p0;
    int cnt;
    int n;
    bit prev;

    compared   = 0;
    mismatched = 0;
    sck0_rises = 0;
    sck1_rises = 0;
    rx0_pulses = 0;
    cs_breaks  = 0;
    watch_cs   = 1'b0;
    sck1_last_rise = 0;
    sck1_prev_rise = 0;
    slave_load = 8'h3C;
    reset      = 1'b1;
    tx_data    = 8'h00;
    tx_dc      = 1'b0;
    tx_last    = 1'b0;
    tx_valid   = 1'b0;
    tx1_data   = 8'h00;
    tx1_valid  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_cs", 32'(cs0), 32'(1));
    checkOutput("reset_sck", 32'(sck0), 32'(0));
    checkOutput("reset_mosi", 32'(mosi0), 32'(0));
    checkOutput("reset_dc", 32'(dc0), 32'(0));
    checkOutput("reset_rxdata", 32'(rx_data), 32'(0));
    checkOutput("reset_rxvalid", 32'(rx_valid), 32'(0));
    checkOutput("reset_busy", 32'(busy0), 32'(0));
    checkOutput("reset_ready", 32'(tx_ready), 32'(0));
    reset = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_reset", 32'(tx_ready), 32'(1));

    // Single byte with loopback, first sck edge timing and cs gap.
    r0 = sck0_rises;
    applyStimulus(8'hA5, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    checkOutput("sck_before_first_rise", 32'(sck0), 32'(0));
    @(negedge clk);
    checkOutput("sck_first_rise", 32'(sck0), 32'(1));
    waitRx0();
    checkOutput("gap0_cs", 32'(cs0), 32'(1));
    checkOutput("gap0_ready", 32'(tx_ready), 32'(0));
    @(negedge clk);
    checkOutput("gap1_cs", 32'(cs0), 32'(1));
    checkOutput("gap1_ready", 32'(tx_ready), 32'(0));
    @(negedge clk);
    checkOutput("gap_end_ready", 32'(tx_ready), 32'(1));
    checkOutput("gap_end_busy", 32'(busy0), 32'(0));
    checkOutput("single_sck_pulses", 32'(sck0_rises - r0), 32'(8));

    // Three-byte burst with back-to-back accepts out of HOLD.
    r0 = sck0_rises;
    p0 = rx0_pulses;
    applyStimulus(8'h2A, 1'b0, 1'b0, 1'b1, 1'b0);
    watch_cs = 1'b1;
    waitRx0();
    applyStimulus(8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    waitRx0();
    applyStimulus(8'hEF, 1'b1, 1'b1, 1'b1, 1'b0);
    waitRx0();
    watch_cs = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("burst_cs_breaks", 32'(cs_breaks), 32'(0));
    checkOutput("burst_sck_pulses", 32'(sck0_rises - r0), 32'(24));
    checkOutput("burst_rx_pulses", 32'(rx0_pulses - p0), 32'(3));

    // Reset at the fifth sck rise aborts the byte.
    p0 = rx0_pulses;
    applyStimulus(8'h5A, 1'b1, 1'b1, 1'b0, 1'b0);
    cnt = 0;
    n = 0;
    prev = 1'b0;
    while (cnt < 5 && n < 1000) begin
      @(negedge clk);
      if (sck0 && !prev) cnt++;
      prev = sck0;
      n++;
    end
    if (cnt < 5) reportTimeout("fifth_rise_wait");
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort_cs", 32'(cs0), 32'(1));
    checkOutput("abort_sck", 32'(sck0), 32'(0));
    checkOutput("abort_rxvalid", 32'(rx_valid), 32'(0));
    checkOutput("abort_busy", 32'(busy0), 32'(0));
    checkOutput("abort_rxdata", 32'(rx_data), 32'(0));
    checkOutput("abort_mosi", 32'(mosi0), 32'(0));
    r0 = sck0_rises;
    reset = 1'b0;
    repeat (100) @(negedge clk);
    checkOutput("abort_no_sck", 32'(sck0_rises - r0), 32'(0));
    checkOutput("abort_no_rx", 32'(rx0_pulses - p0), 32'(0));
    checkOutput("abort_ready", 32'(tx_ready), 32'(1));

    // txValid stays high with changing inputs while the byte is in flight.
    applyStimulus(8'hC3, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      tx_data = 8'($urandom);
      tx_dc   = 1'b0;
      tx_last = 1'($urandom);
    end
    tx_valid = 1'b0;
    checkOutput("inflight_dc", 32'(dc0), 32'(1));
    checkOutput("inflight_cs", 32'(cs0), 32'(0));
    waitRx0();
    repeat (10) @(negedge clk);
    checkOutput("inflight_idle", 32'(busy0), 32'(0));

    // Long HOLD between bytes keeps cs low and MOSI at bit 0.
    applyStimulus(8'h13, 1'b0, 1'b0, 1'b1, 1'b0);
    watch_cs = 1'b1;
    waitRx0();
    repeat (100) @(negedge clk);
    checkOutput("hold_cs", 32'(cs0), 32'(0));
    checkOutput("hold_sck", 32'(sck0), 32'(0));
    checkOutput("hold_mosi", 32'(mosi0), 32'(1));
    checkOutput("hold_busy", 32'(busy0), 32'(1));
    checkOutput("hold_ready", 32'(tx_ready), 32'(1));
    applyStimulus(8'h81, 1'b1, 1'b1, 1'b1, 1'b0);
    waitRx0();
    watch_cs = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("hold_cs_breaks", 32'(cs_breaks), 32'(0));

    // CLK_DIV=1 instance against the slave model.
    r0 = sck1_rises;
    tx1_data  = 8'h00;
    tx1_valid = 1'b1;
    n = 0;
    while (!tx1_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!tx1_ready) reportTimeout("accept1_wait");
    @(posedge clk);
    q1.push_back('{data: 8'h3C, acc: $time});
    #1;
    tx1_valid = 1'b0;
    repeat (30) @(negedge clk);
    checkOutput("div1_sck_pulses", 32'(sck1_rises - r0), 32'(8));
    checkOutput("div1_sck_period", 32'(sck1_last_rise - sck1_prev_rise), 32'(20));
    checkOutput("div1_idle", 32'(busy1), 32'(0));

    checkOutput("q0_drained", 32'(q0.size()), 32'(0));
    checkOutput("q1_drained", 32'(q1.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
